bmp_reader: RTL and testbench
=============================

# bmp_reader

Streams the pixels of a 24-bit BMP image held in byte-addressed memory back out as an RGB pixel stream. It is the consumer-side counterpart of the cropping writer, which produces BMP data bottom-up, in BGR byte order, with each row padded to a 4-byte multiple. The block parses the header fields it needs, then emits pixels top row first, left to right, with row padding removed. Downstream filters and display logic consume its valid/ready stream.

## Interface
- BASE_ADDR, 0: byte address of the first header byte in memory.
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- start  in  1  begin parsing/streaming; sampled only in idle or finished
- done  out  1  high while in finished
- error  out  1  high while in err (bad header)
- readAddr  out  32  byte address to memory
- readdata  in  16  memory data; only bits [7:0] used (one byte per address)
- img_width  out  11  parsed width, valid from first pixel until next start
- img_height  out  11  parsed height, same validity
- pix_valid  out  1  pixel on pix_* is valid
- pix_ready  in  1  downstream accepts pixel when pix_valid && pix_ready
- pix_r, pix_g, pix_b  out  8 each  pixel colour
- pix_x, pix_y  out  11 each  coordinates; (0,0) = top-left
- pix_last  out  1  high with final pixel (x=w-1, y=h-1)

## Operation
- Memory model: readAddr is registered. readdata is sampled on the second cycle that an address is held. Each byte read therefore takes 2 cycles: an addr cycle, then a data cycle.
- States: idle, hdrAddr, hdrData, rowSetup, pixAddr, pixData, emit, finished, err.
- idle: on start, set hdr index 0 and go to hdrAddr.
- Header phase: read bytes BASE_ADDR+10 .. BASE_ADDR+25 (16 bytes, index 0..15) via hdrAddr/hdrData. Fields are captured little-endian:
  - data offset = bytes 10..13 (32 bit)
  - width = bytes 18..21
  - height = bytes 22..25
- After byte 25, validate. If width or height is 0, or any bit above bit 10 is set, go to err. Otherwise go to rowSetup with y=0.
- Padded stride = (3*width + 3) & ~3, held in 32 bits.
- rowSetup (1 cycle): rowBase = BASE_ADDR + dataOffset + (height-1-y)*stride. Set x=0 and byte index b=0.
- Pixel bytes: pixAddr/pixData read rowBase + 3x + b for b = 0,1,2. These map to B, G, R respectively and are captured into pix_b, pix_g, pix_r. After b=2, go to emit.
- emit: pix_valid=1. Hold pix_* stable until pix_ready.
  - On handshake with x<w-1: x+1, b=0, go to pixAddr.
  - With x=w-1 and y<h-1: y+1, go to rowSetup.
  - Otherwise go to finished.
- Padding bytes are never read.
- finished: done=1. A start restarts from hdrAddr (header is re-parsed).
- err: error=1. A start restarts from hdrAddr.
- start is ignored in all other states.
- Width/height registers are 11 bits. Coordinate compares are exact and unsigned, so there is no wrap-around.

## Timing
- Reset: all outputs 0 (done, error, readAddr, pix_*, img_*). State goes to idle; counters are cleared.
- Reset asserted mid-operation aborts immediately. Any pixel in emit is dropped, and pix_valid is 0 on the following cycle.
- Header phase: 32 cycles. The validation/rowSetup decision is made on the cycle after the final data cycle.
- Per pixel: 6 read cycles, then emit for at least 1 cycle. That is 7 cycles per pixel with pix_ready held high, plus 1 rowSetup cycle per row.
- pix_valid falls the cycle after the handshake. It is never asserted in consecutive pixels without the 6-cycle read gap.
- done rises the cycle after the last handshake and stays high until start or reset.
- pix_ready low holds emit indefinitely. Data is stable, and readAddr is stable at the last-read address.

## Test plan
- Header at BASE_ADDR=0: offset=54, width=2, height=2 (stride 8). Bytes 62..64 = 0x10,0x20,0x30 -> first pixel (0,0) has r=0x30, g=0x20, b=0x10. Four pixels in order (0,0),(1,0),(0,1),(1,1); pix_last only on the 4th; done asserts the next cycle.
- width=3, height=1, offset=54 (stride 12): only addresses 54..62 appear on readAddr; 63..65 are never issued. Three pixels are emitted.
- width=0, or width byte 20 = 0x01 -> error=1, no pix_valid, done=0. A subsequent start with a valid header streams normally.
- pix_ready held low 10 cycles during emit -> pix_* unchanged throughout; exactly one handshake when ready rises. Pixel count is still w*h.
- rst_n low mid-row (height 4, during y=2) -> all outputs 0 next cycle. start then re-parses the header and begins at (0,0).
- Two back-to-back runs from finished with different images -> img_width/img_height update. The second stream is correct, and done drops the cycle after start.

Source files
------------

// File: rtl/bmp_reader.sv
// bmp_reader: parses the header of a 24-bit BMP image held in byte-addressed
// memory and streams its pixels out as RGB, top row first, row padding skipped.
module bmp_reader #(
   parameter logic [31:0] BASE_ADDR = 32'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        done,
   output logic        error,
   output logic [31:0] readAddr,
   input  logic [15:0] readdata,
   output logic [10:0] img_width,
   output logic [10:0] img_height,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic [7:0]  pix_r,
   output logic [7:0]  pix_g,
   output logic [7:0]  pix_b,
   output logic [10:0] pix_x,
   output logic [10:0] pix_y,
   output logic        pix_last
);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_HDR_ADDR  = 4'd1;
   localparam logic [3:0] S_HDR_DATA  = 4'd2;
   localparam logic [3:0] S_ROW_SETUP = 4'd3;
   localparam logic [3:0] S_PIX_ADDR  = 4'd4;
   localparam logic [3:0] S_PIX_DATA  = 4'd5;
   localparam logic [3:0] S_EMIT      = 4'd6;
   localparam logic [3:0] S_FINISHED  = 4'd7;
   localparam logic [3:0] S_ERR       = 4'd8;

   // Byte address of pixel byte b (0=B,1=G,2=R) of column x within a row.
   function automatic logic [31:0] pix_addr(input logic [31:0] base,
                                            input logic [10:0] x,
                                            input logic [1:0]  b);
      pix_addr = base + ({21'd0, x} * 32'd3) + {30'd0, b};
   endfunction

   logic [3:0]  state_q,     state_d;
   logic [3:0]  hdr_idx_q,   hdr_idx_d;
   logic [31:0] data_off_q,  data_off_d;
   logic [31:0] width_q,     width_d;
   logic [31:0] height_q,    height_d;
   logic [31:0] row_base_q,  row_base_d;
   logic [10:0] x_q,         x_d;
   logic [10:0] y_q,         y_d;
   logic [1:0]  b_q,         b_d;
   logic [31:0] read_addr_q, read_addr_d;
   logic [7:0]  pix_r_q,     pix_r_d;
   logic [7:0]  pix_g_q,     pix_g_d;
   logic [7:0]  pix_b_q,     pix_b_d;
   logic        pix_valid_q, pix_valid_d;
   logic        pix_last_q,  pix_last_d;
   logic        done_q,      done_d;
   logic        error_q,     error_d;
   logic [10:0] img_w_q,     img_w_d;
   logic [10:0] img_h_q,     img_h_d;

   logic [7:0]  byte_s;
   logic [31:0] stride_s;
   logic [10:0] rows_below_s;
   logic [31:0] row_base_s;
   logic        hdr_bad_s;
   logic [10:0] w_last_s;
   logic [10:0] h_last_s;
   logic        unused_readdata_hi;

   assign byte_s             = readdata[7:0];
   assign unused_readdata_hi = ^readdata[15:8];

   // Geometry derived from the parsed header: padded stride and the memory row
   // that holds display row y (BMP rows are stored bottom-up).
   always_comb begin
      stride_s     = ((width_q * 32'd3) + 32'd3) & ~32'd3;
      rows_below_s = height_q[10:0] - 11'd1 - y_q;
      row_base_s   = BASE_ADDR + data_off_q + ({21'd0, rows_below_s} * stride_s);
      hdr_bad_s    = (width_q == 32'd0) || (height_q == 32'd0) ||
                     (width_q[31:11] != 21'd0) || (height_q[31:11] != 21'd0);
      w_last_s     = width_q[10:0] - 11'd1;
      h_last_s     = height_q[10:0] - 11'd1;
   end

   // Next-state and datapath logic for the header parse / pixel fetch sequence.
   always_comb begin
      state_d     = state_q;
      hdr_idx_d   = hdr_idx_q;
      data_off_d  = data_off_q;
      width_d     = width_q;
      height_d    = height_q;
      row_base_d  = row_base_q;
      x_d         = x_q;
      y_d         = y_q;
      b_d         = b_q;
      read_addr_d = read_addr_q;
      pix_r_d     = pix_r_q;
      pix_g_d     = pix_g_q;
      pix_b_d     = pix_b_q;
      img_w_d     = img_w_q;
      img_h_d     = img_h_q;

      case (state_q)
         S_IDLE, S_FINISHED, S_ERR: begin
            if (start) begin
               hdr_idx_d   = 4'd0;
               read_addr_d = BASE_ADDR + 32'd10;
               state_d     = S_HDR_ADDR;
            end else begin
               state_d = state_q;
            end
         end
         S_HDR_ADDR: begin
            state_d = S_HDR_DATA;
         end
         S_HDR_DATA: begin
            // Header bytes 10..25: fields arrive LSB first, so shift in from the top.
            case (hdr_idx_q[3:2])
               2'b00:   data_off_d = {byte_s, data_off_q[31:8]};
               2'b10:   width_d    = {byte_s, width_q[31:8]};
               2'b11:   height_d   = {byte_s, height_q[31:8]};
               default: data_off_d = data_off_q;
            endcase
            if (hdr_idx_q == 4'd15) begin
               y_d     = 11'd0;
               state_d = S_ROW_SETUP;
            end else begin
               hdr_idx_d   = hdr_idx_q + 4'd1;
               read_addr_d = BASE_ADDR + 32'd11 + {28'd0, hdr_idx_q};
               state_d     = S_HDR_ADDR;
            end
         end
         S_ROW_SETUP: begin
            // The first row setup after the header doubles as header validation.
            if ((y_q == 11'd0) && hdr_bad_s) begin
               state_d = S_ERR;
            end else begin
               if (y_q == 11'd0) begin
                  img_w_d = width_q[10:0];
                  img_h_d = height_q[10:0];
               end else begin
                  img_w_d = img_w_q;
               end
               row_base_d  = row_base_s;
               x_d         = 11'd0;
               b_d         = 2'd0;
               read_addr_d = row_base_s;
               state_d     = S_PIX_ADDR;
            end
         end
         S_PIX_ADDR: begin
            state_d = S_PIX_DATA;
         end
         S_PIX_DATA: begin
            case (b_q)
               2'd0:    pix_b_d = byte_s;
               2'd1:    pix_g_d = byte_s;
               default: pix_r_d = byte_s;
            endcase
            if (b_q == 2'd2) begin
               state_d = S_EMIT;
            end else begin
               b_d         = b_q + 2'd1;
               read_addr_d = pix_addr(row_base_q, x_q, b_q + 2'd1);
               state_d     = S_PIX_ADDR;
            end
         end
         S_EMIT: begin
            if (pix_ready) begin
               if (x_q < w_last_s) begin
                  x_d         = x_q + 11'd1;
                  b_d         = 2'd0;
                  read_addr_d = pix_addr(row_base_q, x_q + 11'd1, 2'd0);
                  state_d     = S_PIX_ADDR;
               end else if (y_q < h_last_s) begin
                  y_d     = y_q + 11'd1;
                  state_d = S_ROW_SETUP;
               end else begin
                  state_d = S_FINISHED;
               end
            end else begin
               state_d = S_EMIT;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      pix_valid_d = (state_d == S_EMIT);
      pix_last_d  = (state_d == S_EMIT) && (x_d == w_last_s) && (y_d == h_last_s);
      done_d      = (state_d == S_FINISHED);
      error_d     = (state_d == S_ERR);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         hdr_idx_q   <= 4'd0;
         data_off_q  <= 32'd0;
         width_q     <= 32'd0;
         height_q    <= 32'd0;
         row_base_q  <= 32'd0;
         x_q         <= 11'd0;
         y_q         <= 11'd0;
         b_q         <= 2'd0;
         read_addr_q <= 32'd0;
         pix_r_q     <= 8'd0;
         pix_g_q     <= 8'd0;
         pix_b_q     <= 8'd0;
         pix_valid_q <= 1'b0;
         pix_last_q  <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         img_w_q     <= 11'd0;
         img_h_q     <= 11'd0;
      end else begin
         state_q     <= state_d;
         hdr_idx_q   <= hdr_idx_d;
         data_off_q  <= data_off_d;
         width_q     <= width_d;
         height_q    <= height_d;
         row_base_q  <= row_base_d;
         x_q         <= x_d;
         y_q         <= y_d;
         b_q         <= b_d;
         read_addr_q <= read_addr_d;
         pix_r_q     <= pix_r_d;
         pix_g_q     <= pix_g_d;
         pix_b_q     <= pix_b_d;
         pix_valid_q <= pix_valid_d;
         pix_last_q  <= pix_last_d;
         done_q      <= done_d;
         error_q     <= error_d;
         img_w_q     <= img_w_d;
         img_h_q     <= img_h_d;
      end
   end

   assign done       = done_q;
   assign error      = error_q;
   assign readAddr   = read_addr_q;
   assign img_width  = img_w_q;
   assign img_height = img_h_q;
   assign pix_valid  = pix_valid_q;
   assign pix_r      = pix_r_q;
   assign pix_g      = pix_g_q;
   assign pix_b      = pix_b_q;
   assign pix_x      = x_q;
   assign pix_y      = y_q;
   assign pix_last   = pix_last_q;

endmodule

// File: tb/tb_bmp_reader.sv
// tb_bmp_reader: random BMP images in a byte memory, checked against a
// reference model that walks the image with plain BMP arithmetic.
module tb_bmp_reader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        done;
   logic        error;
   logic [31:0] readAddr;
   logic [15:0] readdata = 16'd0;
   logic [10:0] img_width;
   logic [10:0] img_height;
   logic        pix_valid;
   logic        pix_ready;
   logic [7:0]  pix_r, pix_g, pix_b;
   logic [10:0] pix_x, pix_y;
   logic        pix_last;

   typedef struct packed {
      logic [7:0]  r;
      logic [7:0]  g;
      logic [7:0]  b;
      logic [10:0] x;
      logic [10:0] y;
      logic        last;
   } pix_t;

   logic [7:0] mem [0:4095];
   pix_t       exp_q[$];
   int         cur_w, cur_h, cur_off;
   int         tests = 0;
   int         fails = 0;
   logic       mon_en = 1'b0;
   int         bad_addr_cnt = 0;
   int         hi_addr_cnt = 0;

   bmp_reader #(.BASE_ADDR(32'd0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .done(done), .error(error),
      .readAddr(readAddr), .readdata(readdata),
      .img_width(img_width), .img_height(img_height),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
      .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last)
   );

   always #5 clk = ~clk;

   // Memory: address held one cycle, data presented during the second.
   always @(posedge clk) readdata <= {8'($urandom), mem[readAddr[11:0]]};

   function automatic bit addr_legal(input logic [31:0] a);
      int ai, stride;
      ai = int'(a);
      stride = ((3 * cur_w + 3) / 4) * 4;
      if (ai >= 10 && ai <= 25) return 1'b1;
      if (cur_w == 0 || ai < cur_off || ai >= cur_off + cur_h * stride) return 1'b0;
      return ((ai - cur_off) % stride) < 3 * cur_w;
   endfunction

   // Address monitor: every issued address must be a header or pixel byte.
   always @(negedge clk) begin
      if (mon_en) begin
         if (!addr_legal(readAddr)) bad_addr_cnt <= bad_addr_cnt + 1;
         if (readAddr >= 32'd63 && readAddr <= 32'd65) hi_addr_cnt <= hi_addr_cnt + 1;
      end
   end

   task automatic build_expected();
      int stride, a;
      pix_t p;
      exp_q.delete();
      stride = ((3 * cur_w + 3) / 4) * 4;
      for (int y = 0; y < cur_h; y++) begin
         for (int x = 0; x < cur_w; x++) begin
            a = cur_off + (cur_h - 1 - y) * stride + 3 * x;
            p.b = mem[a];
            p.g = mem[a + 1];
            p.r = mem[a + 2];
            p.x = 11'(x);
            p.y = 11'(y);
            p.last = (x == cur_w - 1) && (y == cur_h - 1);
            exp_q.push_back(p);
         end
      end
   endtask

   task automatic load_image(input int off, input logic [31:0] wf, input logic [31:0] hf);
      logic [31:0] o;
      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
      o = 32'(off);
      for (int k = 0; k < 4; k++) begin
         mem[10 + k] = o[8*k +: 8];
         mem[18 + k] = wf[8*k +: 8];
         mem[22 + k] = hf[8*k +: 8];
      end
      cur_off = off;
      if (wf != 32'd0 && hf != 32'd0 && wf < 32'd2048 && hf < 32'd2048) begin
         cur_w = int'(wf);
         cur_h = int'(hf);
      end else begin
         cur_w = 0;
         cur_h = 0;
      end
      build_expected();
   endtask

   task automatic start_pulse();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      mon_en = 1'b1;
   endtask

   // mode 0: ready always high; 1: random ready; 2: stall first pixel 10 cycles.
   task automatic stream_check(input string name, input int mode);
      int first_v, done_c, last_hs, stall, n, npix, bad0, h0;
      bit prev_hs;
      pix_t got, want, snap;
      logic [31:0] snap_addr;
      first_v = -1; done_c = -1; last_hs = -1; stall = 0; n = 0; prev_hs = 1'b0;
      snap = '0; snap_addr = 32'd0;
      npix = exp_q.size();
      bad0 = bad_addr_cnt; h0 = hi_addr_cnt;
      for (int cyc = 0; cyc < 20000; cyc++) begin
         if (prev_hs) begin
            tests++;
            if (pix_valid !== 1'b0) begin
               fails++;
               $display("FAIL %s valid_drop: pix_valid=%b required 0", name, pix_valid);
            end
         end
         prev_hs = 1'b0;
         if (pix_valid === 1'b1 && first_v < 0) first_v = cyc;
         if (done === 1'b1 || error === 1'b1) begin
            done_c = cyc;
            break;
         end
         got = {pix_r, pix_g, pix_b, pix_x, pix_y, pix_last};
         if (mode == 0) begin
            pix_ready = 1'b1;
         end else if (mode == 2) begin
            if (pix_valid === 1'b1 && n == 0) begin
               if (stall == 0) begin
                  snap = got;
                  snap_addr = readAddr;
               end else begin
                  tests++;
                  if ({got, readAddr, pix_valid} !== {snap, snap_addr, 1'b1}) begin
                     fails++;
                     $display("FAIL %s stall_hold: got %h addr %h required %h addr %h",
                              name, got, readAddr, snap, snap_addr);
                  end
               end
               pix_ready = (stall >= 10);
               stall++;
            end else begin
               pix_ready = (n > 0);
            end
         end else begin
            pix_ready = ($urandom_range(0, 9) < 7);
         end
         if (pix_valid === 1'b1 && pix_ready === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL %s extra_pixel: got %h required none", name, got);
            end else begin
               want = exp_q.pop_front();
               if (got !== want) begin
                  fails++;
                  $display("FAIL %s pixel%0d: got rgb=%h%h%h x=%0d y=%0d last=%b required rgb=%h%h%h x=%0d y=%0d last=%b",
                           name, n, got.r, got.g, got.b, got.x, got.y, got.last,
                           want.r, want.g, want.b, want.x, want.y, want.last);
               end
            end
            n++;
            last_hs = cyc;
            prev_hs = 1'b1;
         end
         @(negedge clk);
      end
      tests++;
      if (done_c < 0 || done !== 1'b1 || error !== 1'b0) begin
         fails++;
         $display("FAIL %s done: done=%b error=%b at cycle %0d required done=1 error=0", name, done, error, done_c);
      end
      tests++;
      if (n != npix || exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s count: got %0d pixels required %0d", name, n, npix);
      end
      tests++;
      if (first_v != 39) begin
         fails++;
         $display("FAIL %s first_latency: got %0d required 39", name, first_v);
      end
      tests++;
      if (done_c != last_hs + 1) begin
         fails++;
         $display("FAIL %s done_timing: done at %0d required %0d", name, done_c, last_hs + 1);
      end
      if (mode == 0) begin
         tests++;
         if (done_c != 32 + cur_h * (1 + 7 * cur_w)) begin
            fails++;
            $display("FAIL %s total_cycles: got %0d required %0d", name, done_c, 32 + cur_h * (1 + 7 * cur_w));
         end
      end
      tests++;
      if (img_width !== 11'(cur_w) || img_height !== 11'(cur_h)) begin
         fails++;
         $display("FAIL %s img_dims: got %0dx%0d required %0dx%0d", name, img_width, img_height, cur_w, cur_h);
      end
      mon_en = 1'b0;
      @(negedge clk);
      tests++;
      if (bad_addr_cnt != bad0) begin
         fails++;
         $display("FAIL %s addr_legal: got %0d illegal reads required 0", name, bad_addr_cnt - bad0);
      end
      if (cur_off == 54 && cur_w == 3 && cur_h == 1) begin
         tests++;
         if (hi_addr_cnt != h0) begin
            fails++;
            $display("FAIL %s pad_63_65: got %0d reads required 0", name, hi_addr_cnt - h0);
         end
      end
   endtask

   task automatic check_all_zero(input string name);
      tests++;
      if ({done, error, readAddr, img_width, img_height, pix_valid, pix_r, pix_g, pix_b,
           pix_x, pix_y, pix_last} !== 104'd0) begin
         fails++;
         $display("FAIL %s all_zero: done=%b err=%b addr=%h valid=%b rgb=%h%h%h xy=%0d,%0d img=%0dx%0d required all 0",
                  name, done, error, readAddr, pix_valid, pix_r, pix_g, pix_b, pix_x, pix_y, img_width, img_height);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; pix_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_all_zero("reset_idle");
   endtask

   task automatic test_basic();
      load_image(54, 32'd2, 32'd2);
      mem[62] = 8'h10; mem[63] = 8'h20; mem[64] = 8'h30;
      build_expected();
      start_pulse();
      stream_check("basic_2x2", 0);
   endtask

   task automatic test_no_padding();
      load_image(54, 32'd3, 32'd1);
      start_pulse();
      stream_check("w3_h1", 0);
   endtask

   task automatic test_bad_header(input string name, input logic [31:0] wf, input logic [31:0] hf);
      int err_c, b0;
      bit saw_v;
      load_image(54, wf, hf);
      b0 = bad_addr_cnt;
      start_pulse();
      err_c = -1; saw_v = 1'b0;
      for (int c = 0; c < 60; c++) begin
         if (pix_valid === 1'b1) saw_v = 1'b1;
         if (error === 1'b1 && err_c < 0) err_c = c;
         @(negedge clk);
      end
      mon_en = 1'b0;
      tests++;
      if (err_c != 33 || error !== 1'b1) begin
         fails++;
         $display("FAIL %s error_timing: error first at %0d now %b required 33 and 1", name, err_c, error);
      end
      tests++;
      if (saw_v || done !== 1'b0) begin
         fails++;
         $display("FAIL %s no_output: saw_valid=%b done=%b required 0 0", name, saw_v, done);
      end
      tests++;
      if (bad_addr_cnt != b0) begin
         fails++;
         $display("FAIL %s hdr_addr: got %0d illegal reads required 0", name, bad_addr_cnt - b0);
      end
   endtask

   task automatic test_stall();
      load_image(60, 32'd3, 32'd2);
      start_pulse();
      stream_check("stall", 2);
   endtask

   task automatic test_reset_mid();
      bit found;
      load_image(40, 32'd3, 32'd4);
      start_pulse();
      pix_ready = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 2000 && !found; c++) begin
         if (pix_valid === 1'b1 && pix_y === 11'd2) found = 1'b1;
         else @(negedge clk);
      end
      tests++;
      if (!found) begin
         fails++;
         $display("FAIL reset_mid reach_row2: got no pixel at y=2 required one");
      end
      mon_en = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      check_all_zero("reset_mid");
      rst_n = 1'b1;
      @(negedge clk);
      start_pulse();
      stream_check("after_reset", 0);
   endtask

   task automatic test_back_to_back();
      load_image(70, 32'd2, 32'd3);
      start_pulse();
      stream_check("b2b_first", 1);
      load_image(30, 32'd5, 32'd2);
      tests++;
      if (done !== 1'b1) begin
         fails++;
         $display("FAIL b2b done_before: got %b required 1", done);
      end
      start_pulse();
      tests++;
      if (done !== 1'b0) begin
         fails++;
         $display("FAIL b2b done_drop: got %b required 0", done);
      end
      stream_check("b2b_second", 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 4; i++) begin
         load_image(int'($urandom_range(26, 90)), 32'($urandom_range(1, 6)), 32'($urandom_range(1, 4)));
         start_pulse();
         stream_check("random", 1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_no_padding();
      test_bad_header("width0", 32'd0, 32'd2);
      test_bad_header("width_hi", 32'h0001_0002, 32'd2);
      test_basic();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
